// File: rtl/siggen_pkg.sv
// -----------------------------------------------------------------------------
// siggen_pkg
// Shared constants and types for the signal-generator phase path.
//   ADDR_W     : sine ROM address width
//   FRAC_W     : fractional phase bits below the ROM address
//   ACC_W      : full phase accumulator / tuning word width
//   INCR_RESET : tuning word that advances exactly one ROM address per cycle
// -----------------------------------------------------------------------------
package siggen_pkg;

    localparam int ADDR_W = 8;
    localparam int FRAC_W = 8;
    localparam int ACC_W  = ADDR_W + FRAC_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ACC_W-1:0]  acc_t;

    localparam acc_t INCR_RESET = acc_t'(1) << FRAC_W;

endpackage : siggen_pkg

// File: rtl/phase_shadow_reg.sv
// -----------------------------------------------------------------------------
// phase_shadow_reg
// Double-buffered tuning word / phase offset. New values are captured into
// shadow registers on load and copied to the active registers only when the
// accumulator wraps, or immediately when stepping is paused.
//
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   en               : accumulator is stepping this cycle
//   carry            : accumulator carry-out this cycle (already qualified by en)
//   load             : capture incr/offset into the shadows
//   incr, offset     : candidate tuning word and phase offset
//   active_incr      : tuning word currently used by the accumulator
//   active_offset    : phase offset currently used for addr2
//   shadow_offset    : pending offset (used for addr2 on an applying edge)
//   apply            : combinational pulse, shadows copied to active this edge
//   update_pending   : shadows hold values not yet applied
// -----------------------------------------------------------------------------
module phase_shadow_reg #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int FRAC_WIDTH    = 8,
    parameter int ACC_WIDTH     = ADDRESS_WIDTH + FRAC_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     carry,
    input  logic                     load,
    input  logic [ACC_WIDTH-1:0]     incr,
    input  logic [ADDRESS_WIDTH-1:0] offset,
    output logic [ACC_WIDTH-1:0]     active_incr,
    output logic [ADDRESS_WIDTH-1:0] active_offset,
    output logic [ADDRESS_WIDTH-1:0] shadow_offset,
    output logic                     apply,
    output logic                     update_pending
);

    localparam logic [ACC_WIDTH-1:0] INCR_UNITY = ACC_WIDTH'(1) << FRAC_WIDTH;

    logic [ACC_WIDTH-1:0]     r_shadow_incr;
    logic [ADDRESS_WIDTH-1:0] r_shadow_offset;
    logic [ACC_WIDTH-1:0]     r_active_incr;
    logic [ADDRESS_WIDTH-1:0] r_active_offset;
    logic                     r_pending;
    logic                     w_apply;

    // Paused: apply at once. Running: apply only on the wrap edge so the
    // waveform period in flight is never cut short.
    assign w_apply = r_pending & (~en | carry);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow_incr   <= '0;
            r_shadow_offset <= '0;
            r_active_incr   <= INCR_UNITY;
            r_active_offset <= '0;
            r_pending       <= 1'b0;
        end else begin
            if (w_apply) begin
                r_active_incr   <= r_shadow_incr;
                r_active_offset <= r_shadow_offset;
            end
            // A load on an applying edge refills the shadows after the old
            // contents were handed over, so pending must stay set.
            if (load) begin
                r_shadow_incr   <= incr;
                r_shadow_offset <= offset;
                r_pending       <= 1'b1;
            end else if (w_apply) begin
                r_pending       <= 1'b0;
            end
        end
    end

    assign active_incr    = r_active_incr;
    assign active_offset  = r_active_offset;
    assign shadow_offset  = r_shadow_offset;
    assign apply          = w_apply;
    assign update_pending = r_pending;

endmodule : phase_shadow_reg

// File: rtl/phase_addr_gen.sv
// -----------------------------------------------------------------------------
// phase_addr_gen
// Phase-accumulator address generator for a dual-port sine ROM.
// addr1 is the integer part of the accumulator, addr2 = addr1 + phase offset.
// Tuning word / offset changes are double-buffered and take effect at a wrap.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   en              : advance the accumulator this cycle
//   incr            : tuning word, captured on load
//   offset          : addr2 phase offset, captured on load
//   load            : one-cycle capture strobe
//   addr1, addr2    : registered ROM addresses
//   wrap            : one-cycle pulse on accumulator carry-out
//   update_pending  : captured values not yet applied
//   addr_valid      : addresses came from an enabled step
//   dout_valid      : addr_valid aligned to the ROM read latency
// -----------------------------------------------------------------------------
module phase_addr_gen
    import siggen_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDR_W,
    parameter int FRAC_WIDTH    = FRAC_W,
    parameter int ACC_WIDTH     = ADDRESS_WIDTH + FRAC_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [ACC_WIDTH-1:0]     incr,
    input  logic [ADDRESS_WIDTH-1:0] offset,
    input  logic                     load,
    output logic [ADDRESS_WIDTH-1:0] addr1,
    output logic [ADDRESS_WIDTH-1:0] addr2,
    output logic                     wrap,
    output logic                     update_pending,
    output logic                     addr_valid,
    output logic                     dout_valid
);

    logic [ACC_WIDTH-1:0]     r_acc;
    logic [ADDRESS_WIDTH-1:0] r_addr1;
    logic [ADDRESS_WIDTH-1:0] r_addr2;
    logic                     r_wrap;
    logic                     r_addr_valid;
    logic                     r_dout_valid;

    logic [ACC_WIDTH:0]       w_sum;
    logic                     w_carry;
    logic [ACC_WIDTH-1:0]     w_acc_next;
    logic [ADDRESS_WIDTH-1:0] w_addr1_next;
    logic [ADDRESS_WIDTH-1:0] w_addr2_next;
    logic [ADDRESS_WIDTH-1:0] w_offset_used;
    logic [ACC_WIDTH-1:0]     w_active_incr;
    logic [ADDRESS_WIDTH-1:0] w_active_offset;
    logic [ADDRESS_WIDTH-1:0] w_shadow_offset;
    logic                     w_apply;

    phase_shadow_reg #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .FRAC_WIDTH    (FRAC_WIDTH),
        .ACC_WIDTH     (ACC_WIDTH)
    ) u_shadow (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .carry          (en & w_carry),
        .load           (load),
        .incr           (incr),
        .offset         (offset),
        .active_incr    (w_active_incr),
        .active_offset  (w_active_offset),
        .shadow_offset  (w_shadow_offset),
        .apply          (w_apply),
        .update_pending (update_pending)
    );

    // The step always uses the tuning word active before this edge; a new
    // word only affects the step after it is applied.
    assign w_sum        = {1'b0, r_acc} + {1'b0, w_active_incr};
    assign w_carry      = w_sum[ACC_WIDTH];
    assign w_acc_next   = w_sum[ACC_WIDTH-1:0];
    assign w_addr1_next = w_acc_next[ACC_WIDTH-1:FRAC_WIDTH];

    // On the applying edge addr2 already uses the new offset, so both the
    // frequency and phase change line up with the wrap.
    assign w_offset_used = w_apply ? w_shadow_offset : w_active_offset;
    assign w_addr2_next  = w_addr1_next + w_offset_used;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc        <= '0;
            r_addr1      <= '0;
            r_addr2      <= '0;
            r_wrap       <= 1'b0;
            r_addr_valid <= 1'b0;
            r_dout_valid <= 1'b0;
        end else begin
            r_addr_valid <= en;
            r_dout_valid <= r_addr_valid;
            if (en) begin
                r_acc   <= w_acc_next;
                r_addr1 <= w_addr1_next;
                r_addr2 <= w_addr2_next;
                r_wrap  <= w_carry;
            end else begin
                r_wrap  <= 1'b0;
            end
        end
    end

    assign addr1      = r_addr1;
    assign addr2      = r_addr2;
    assign wrap       = r_wrap;
    assign addr_valid = r_addr_valid;
    assign dout_valid = r_dout_valid;

endmodule : phase_addr_gen

// File: tb/tb_phase_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_phase_addr_gen
// Directed bench for phase_addr_gen (default 8.8 accumulator). Inputs change
// just after the falling edge; outputs are checked on the next falling edge,
// i.e. one rising edge after the stimulus.
// -----------------------------------------------------------------------------
module tb_phase_addr_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] incr;
    logic [7:0]  offset;
    logic        load;
    logic [7:0]  addr1;
    logic [7:0]  addr2;
    logic        wrap;
    logic        update_pending;
    logic        addr_valid;
    logic        dout_valid;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    phase_addr_gen dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .incr           (incr),
        .offset         (offset),
        .load           (load),
        .addr1          (addr1),
        .addr2          (addr2),
        .wrap           (wrap),
        .update_pending (update_pending),
        .addr_valid     (addr_valid),
        .dout_valid     (dout_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, got, exp, $time);
            $error("%s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs and wait until the outputs have settled.
    task automatic step(input logic s_rst, input logic s_en, input logic s_load,
                        input logic [15:0] s_incr, input logic [7:0] s_off);
        rst    = s_rst;
        en     = s_en;
        load   = s_load;
        incr   = s_incr;
        offset = s_off;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic exp4(input string tag, input int a1, input int a2,
                        input logic wr, input logic pend);
        chk({tag, ".addr1"}, 32'(addr1), 32'(a1 & 255));
        chk({tag, ".addr2"}, 32'(addr2), 32'(a2 & 255));
        chk({tag, ".wrap"},  32'(wrap),  32'(wr));
        chk({tag, ".pend"},  32'(update_pending), 32'(pend));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; incr = '0; offset = '0;
        @(negedge clk);

        // Reset state
        step(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
        exp4("reset", 0, 0, 1'b0, 1'b0);
        chk("reset.addr_valid", 32'(addr_valid), 32'd0);
        chk("reset.dout_valid", 32'(dout_valid), 32'd0);

        // Default tuning: one address per cycle, wrap after 256 steps
        for (int k = 1; k <= 260; k++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
            exp4("dflt", k, k, (k == 256), 1'b0);
            chk("dflt.addr_valid", 32'(addr_valid), 32'd1);
            chk("dflt.dout_valid", 32'(dout_valid), 32'(k >= 2));
        end

        // Load half-rate word while paused; applies on the next paused edge
        step(1'b0, 1'b0, 1'b1, 16'h0080, 8'd64);
        exp4("ld_paused", 4, 4, 1'b0, 1'b1);
        chk("ld_paused.addr_valid", 32'(addr_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        exp4("apply_paused", 4, 4, 1'b0, 1'b0);
        chk("apply_paused.dout_valid", 32'(dout_valid), 32'd0);
        for (int n = 1; n <= 400; n++) begin
            int a;
            a = (16'h0400 + n * 16'h0080) >> 8;
            step(1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
            exp4("half", a, a + 64, 1'b0, 1'b0);
        end

        // Restart at default rate, load double rate at addr1=10
        step(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
        exp4("reset2", 0, 0, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
            exp4("run1", k, k, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 1'b1, 16'h0200, 8'h0);
        exp4("ld_x2", 11, 11, 1'b0, 1'b1);
        for (int i = 12; i <= 255; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
            exp4("wait_wrap", i, i, 1'b0, 1'b1);
        end
        step(1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
        exp4("wrap_apply", 0, 0, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
            exp4("x2", 2 * k, 2 * k, 1'b0, 1'b0);
        end

        // Two loads before the wrap: only the later offset takes effect
        step(1'b0, 1'b1, 1'b1, 16'h0200, 8'd128);
        exp4("ld_off128", 8, 8, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 16'h0200, 8'd32);
        exp4("ld_off32", 10, 10, 1'b0, 1'b1);
        for (int i = 12; i <= 254; i += 2) begin
            step(1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
            exp4("off_wait", i, i, 1'b0, 1'b1);
        end
        step(1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
        exp4("off_apply", 0, 32, 1'b1, 1'b0);
        for (int k = 1; k <= 127; k++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
            exp4("off32", 2 * k, 2 * k + 32, 1'b0, 1'b0);
        end

        // Load exactly on the wrap edge with nothing pending: deferred a wrap
        step(1'b0, 1'b1, 1'b1, 16'h0100, 8'd0);
        exp4("ld_on_wrap", 0, 32, 1'b1, 1'b1);
        for (int k = 1; k <= 127; k++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
            exp4("deferred", 2 * k, 2 * k + 32, 1'b0, 1'b1);
        end
        step(1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
        exp4("deferred_apply", 0, 0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
        exp4("x1_again", 1, 1, 1'b0, 1'b0);

        // Reset mid-run with an update pending
        step(1'b0, 1'b1, 1'b1, 16'h0300, 8'd5);
        exp4("ld_before_rst", 2, 2, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 16'h0, 8'h0);
        exp4("rst_mid", 0, 0, 1'b0, 1'b0);
        chk("rst_mid.addr_valid", 32'(addr_valid), 32'd0);
        chk("rst_mid.dout_valid", 32'(dout_valid), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
            exp4("post_rst", k, k, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_phase_addr_gen
